// File: rtl/agc_a19_io.sv
// agc_a19_io: AGC tray-A I/O module A19 -- channel 11/13/14 output latches,
// counter pulse generation for gyro/thrust/EMS/altimeter/links, T1P..T6P timing.
`default_nettype none

module agc_a19_io (
  input  logic CLOCK,
  input  logic rst,
  input  logic CHWL01_, input logic CHWL02_, input logic CHWL03_, input logic CHWL04_,
  input  logic CHWL05_, input logic CHWL06_, input logic CHWL07_, input logic CHWL08_,
  input  logic CHWL09_, input logic CHWL10_, input logic CHWL11_, input logic CHWL12_,
  input  logic WCH11_, input logic WCH13_, input logic WCH14_,
  input  logic RCH11_, input logic RCH13_, input logic RCH14_, input logic RCH33_,
  input  logic CCH11, input logic CCH13, input logic CCH14,
  input  logic CCHG_, input logic XT3_, input logic XB3_, input logic XB5_, input logic XB6_,
  input  logic XB7_, input logic CXB0_, input logic CXB7_, input logic CA2_, input logic CA4_,
  input  logic CA5_, input logic CA6_, input logic CNTRSB_,
  input  logic POUT_, input logic MOUT_, input logic ZOUT_, input logic OVF_,
  input  logic WOVR_, input logic SHINC_,
  input  logic F04A, input logic F06B, input logic F07B, input logic F09B, input logic F10A,
  input  logic F10B, input logic FS10, input logic F05A_, input logic F05B_, input logic F07C_,
  input  logic F07D_, input logic F7CSB1_, input logic SB0_, input logic SB1_, input logic SB2_,
  input  logic GTSET, input logic GTSET_, input logic GTONE, input logic GOJAM, input logic CSG,
  input  logic CGA19, input logic C45R, input logic T06_, input logic T6ON_, input logic BR1,
  input  logic BR1_,
  input  logic UPL0, input logic UPL1, input logic XLNK0, input logic XLNK1, input logic BLKUPL_,
  input  logic BMGXP, input logic BMGXM, input logic BMGYP, input logic BMGYM,
  input  logic BMGZP, input logic BMGZM, input logic SIGNX, input logic SIGNY, input logic SIGNZ,
  input  logic GATEX_, input logic GATEY_, input logic GATEZ_,
  output logic BLKUPL, output logic C45R_, output logic F06B_, output logic F09B_,
  output logic F10A_, output logic F10B_, output logic UPL0_, output logic UPL1_,
  output logic XLNK0_, output logic XLNK1_, output logic F5ASB0, output logic F5ASB0_,
  output logic F5ASB2, output logic F5ASB2_, output logic F5BSB2, output logic F5BSB2_,
  output logic CCH33, output logic W1110,
  output logic BMAGXP, output logic BMAGXM, output logic BMAGYP, output logic BMAGYM,
  output logic BMAGZP, output logic BMAGZM,
  output logic FF1109, output logic FF1110, output logic FF1111, output logic FF1112,
  output logic FF1109_, output logic FF1110_, output logic FF1111_, output logic FF1112_,
  output logic CH1109, output logic CH1110, output logic CH1111, output logic CH1112,
  output logic CH1305, output logic CH1306, output logic CH1308, output logic CH1309,
  output logic CH1401, output logic CH1402, output logic CH1403, output logic CH1404,
  output logic CH1405, output logic CH1406, output logic CH1407, output logic CH1408,
  output logic CH1409, output logic CH1410, output logic CH3310, output logic CH3311,
  output logic GYENAB, output logic GYROD, output logic GYRSET, output logic GYRRST,
  output logic GYXP, output logic GYXM, output logic GYYP, output logic GYYM,
  output logic GYZP, output logic GYZM,
  output logic THRSTD, output logic THRSTp, output logic THRSTm,
  output logic EMSD, output logic EMSp, output logic EMSm,
  output logic ALTM, output logic ALT0, output logic ALT1, output logic ALRT0,
  output logic ALRT1, output logic ALTSNC,
  output logic OTLNK0, output logic OTLNK1, output logic OTLNKM,
  output logic INLNKP, output logic INLNKM, output logic UPRUPT, output logic RHCGO,
  output logic SH3MS_,
  output logic T1P, output logic T2P, output logic T3P, output logic T4P, output logic T5P,
  output logic T6P
);

  typedef enum logic [2:0] {
    TS1 = 3'd0, TS2 = 3'd1, TS3 = 3'd2, TS4 = 3'd3, TS5 = 3'd4, TS6 = 3'd5
  } tstate_t;

  logic [12:9] ch11_q, ch11_d;
  logic [3:0]  ch13_q, ch13_d;   // {bit9, bit8, bit6, bit5}
  logic [10:1] ch14_q, ch14_d;

  logic thrp_q, thrp_d, thrm_q, thrm_d;
  logic emsp_q, emsp_d, emsm_q, emsm_d;
  logic upl0_q, upl1_q, xlnk0_q, xlnk1_q, f10a_q;
  logic inlnkp_q, inlnkp_d, inlnkm_q, inlnkm_d;
  logic seenp_q, seenp_d, seenm_q, seenm_d;
  logic ch3311_q, ch3311_d;
  logic uprupt_q, uprupt_d;
  logic [6:1] tp_q, tp_d;
  tstate_t tstate_q, tstate_d;

  logic f10a_rise, p_any, m_any;
  logic gy_act, gy_p, gy_m;
  logic unused_ok;

  // Simple inverters, strobes and decodes
  assign BLKUPL  = ~BLKUPL_;
  assign C45R_   = ~C45R;
  assign F06B_   = ~F06B;
  assign F09B_   = ~F09B;
  assign F10A_   = ~F10A;
  assign F10B_   = ~F10B;
  assign UPL0_   = ~UPL0;
  assign UPL1_   = ~UPL1;
  assign XLNK0_  = ~XLNK0;
  assign XLNK1_  = ~XLNK1;
  assign F5ASB0  = ~(F05A_ | SB0_);
  assign F5ASB0_ = ~F5ASB0;
  assign F5ASB2  = ~(F05A_ | SB2_);
  assign F5ASB2_ = ~F5ASB2;
  assign F5BSB2  = ~(F05B_ | SB2_);
  assign F5BSB2_ = ~F5BSB2;
  assign CCH33   = ~(CCHG_ | XT3_ | XB3_);
  assign W1110   = ~WCH11_ & ~CHWL10_;
  assign BMAGXP  = BMGXP & F04A;
  assign BMAGXM  = BMGXM & F04A;
  assign BMAGYP  = BMGYP & F04A;
  assign BMAGYM  = BMGYM & F04A;
  assign BMAGZP  = BMGZP & F04A;
  assign BMAGZM  = BMGZM & F04A;

  // Channel latches: a write in the same cycle as a clear wins
  always_comb begin
    ch11_d = ch11_q;
    if (!WCH11_)     ch11_d = ~{CHWL12_, CHWL11_, CHWL10_, CHWL09_};
    else if (CCH11)  ch11_d = '0;
    ch13_d = ch13_q;
    if (!WCH13_)     ch13_d = ~{CHWL09_, CHWL08_, CHWL06_, CHWL05_};
    else if (CCH13)  ch13_d = '0;
    ch14_d = ch14_q;
    if (!WCH14_)     ch14_d = ~{CHWL10_, CHWL09_, CHWL08_, CHWL07_, CHWL06_,
                                CHWL05_, CHWL04_, CHWL03_, CHWL02_, CHWL01_};
    else if (CCH14)  ch14_d = '0;
  end

  assign FF1109  = ch11_q[9];
  assign FF1110  = ch11_q[10];
  assign FF1111  = ch11_q[11];
  assign FF1112  = ch11_q[12];
  assign FF1109_ = ~ch11_q[9];
  assign FF1110_ = ~ch11_q[10];
  assign FF1111_ = ~ch11_q[11];
  assign FF1112_ = ~ch11_q[12];
  assign CH1109  = ch11_q[9]  & ~RCH11_;
  assign CH1110  = ch11_q[10] & ~RCH11_;
  assign CH1111  = ch11_q[11] & ~RCH11_;
  assign CH1112  = ch11_q[12] & ~RCH11_;
  assign CH1305  = ch13_q[0] & ~RCH13_;
  assign CH1306  = ch13_q[1] & ~RCH13_;
  assign CH1308  = ch13_q[2] & ~RCH13_;
  assign CH1309  = ch13_q[3] & ~RCH13_;
  assign CH1401  = ch14_q[1]  & ~RCH14_;
  assign CH1402  = ch14_q[2]  & ~RCH14_;
  assign CH1403  = ch14_q[3]  & ~RCH14_;
  assign CH1404  = ch14_q[4]  & ~RCH14_;
  assign CH1405  = ch14_q[5]  & ~RCH14_;
  assign CH1406  = ch14_q[6]  & ~RCH14_;
  assign CH1407  = ch14_q[7]  & ~RCH14_;
  assign CH1408  = ch14_q[8]  & ~RCH14_;
  assign CH1409  = ch14_q[9]  & ~RCH14_;
  assign CH1410  = ch14_q[10] & ~RCH14_;
  assign CH3310  = BLKUPL & ~RCH33_;
  assign CH3311  = ch3311_q & ~RCH33_;

  // Channel 14 control fields and gyro drive
  assign ALTM   = ch14_q[2];
  assign ALTSNC = ch14_q[3];
  assign THRSTD = ch14_q[4];
  assign EMSD   = ch14_q[5];
  assign GYENAB = ch14_q[6];
  assign GYROD  = ch14_q[10];
  assign gy_act = GYENAB & GYROD & F5ASB2;
  assign gy_p   = gy_act & ~ch14_q[9];
  assign gy_m   = gy_act &  ch14_q[9];
  assign GYXP   = gy_p & (ch14_q[8:7] == 2'b01);
  assign GYXM   = gy_m & (ch14_q[8:7] == 2'b01);
  assign GYYP   = gy_p & (ch14_q[8:7] == 2'b10);
  assign GYYM   = gy_m & (ch14_q[8:7] == 2'b10);
  assign GYZP   = gy_p & (ch14_q[8:7] == 2'b11);
  assign GYZM   = gy_m & (ch14_q[8:7] == 2'b11);
  assign GYRSET = GTSET & GYROD;
  assign GYRRST = GTONE & ~GYROD;

  assign ALT1   = ALTM & ~CA5_ & ~POUT_;
  assign ALT0   = ALTM & ~CA5_ & ~ZOUT_;
  assign ALRT1  = ch14_q[1] & ~CA6_ & ~POUT_;
  assign ALRT0  = ch14_q[1] & ~CA6_ & ~ZOUT_;
  assign OTLNK1 = ~CXB7_ & ~CNTRSB_ & ~POUT_;
  assign OTLNK0 = ~CXB7_ & ~CNTRSB_ & ~ZOUT_;
  assign OTLNKM = ~CXB7_ & ~CNTRSB_ & ~MOUT_;

  assign THRSTp = thrp_q;
  assign THRSTm = thrm_q;
  assign EMSp   = emsp_q;
  assign EMSm   = emsm_q;
  assign INLNKP = inlnkp_q;
  assign INLNKM = inlnkm_q;
  assign UPRUPT = uprupt_q;
  assign RHCGO  = ~T06_ & ~T6ON_ & ~GOJAM;
  assign SH3MS_ = ~(F07B & ~SHINC_);

  assign f10a_rise = F10A & ~f10a_q;
  // A pulse issued this cycle counts toward the current F10A period
  assign p_any = seenp_q | inlnkp_q;
  assign m_any = seenm_q | inlnkm_q;

  always_comb begin
    thrp_d    = THRSTD & ~CA2_ & ~POUT_;
    thrm_d    = THRSTD & ~CA2_ & ~MOUT_;
    emsp_d    = EMSD & ~CA4_ & ~POUT_;
    emsm_d    = EMSD & ~CA4_ & ~MOUT_;
    inlnkp_d  = (UPL1 & ~upl1_q & ~BLKUPL) | (XLNK1 & ~xlnk1_q);
    inlnkm_d  = (UPL0 & ~upl0_q & ~BLKUPL) | (XLNK0 & ~xlnk0_q);
    seenp_d   = f10a_rise ? 1'b0 : p_any;
    seenm_d   = f10a_rise ? 1'b0 : m_any;
    ch3311_d  = ch3311_q | (p_any & m_any);
    uprupt_d  = uprupt_q;
    if (GOJAM || C45R)                   uprupt_d = 1'b0;
    else if (!OVF_ && !CNTRSB_ && !XB5_) uprupt_d = 1'b1;
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      ch11_q   <= '0;
      ch13_q   <= '0;
      ch14_q   <= '0;
      thrp_q   <= 1'b0;
      thrm_q   <= 1'b0;
      emsp_q   <= 1'b0;
      emsm_q   <= 1'b0;
      upl0_q   <= 1'b0;
      upl1_q   <= 1'b0;
      xlnk0_q  <= 1'b0;
      xlnk1_q  <= 1'b0;
      f10a_q   <= 1'b0;
      inlnkp_q <= 1'b0;
      inlnkm_q <= 1'b0;
      seenp_q  <= 1'b0;
      seenm_q  <= 1'b0;
      ch3311_q <= 1'b0;
      uprupt_q <= 1'b0;
      tp_q     <= '0;
    end else begin
      ch11_q   <= ch11_d;
      ch13_q   <= ch13_d;
      ch14_q   <= ch14_d;
      thrp_q   <= thrp_d;
      thrm_q   <= thrm_d;
      emsp_q   <= emsp_d;
      emsm_q   <= emsm_d;
      upl0_q   <= UPL0;
      upl1_q   <= UPL1;
      xlnk0_q  <= XLNK0;
      xlnk1_q  <= XLNK1;
      f10a_q   <= F10A;
      inlnkp_q <= inlnkp_d;
      inlnkm_q <= inlnkm_d;
      seenp_q  <= seenp_d;
      seenm_q  <= seenm_d;
      ch3311_q <= ch3311_d;
      uprupt_q <= uprupt_d;
      tp_q     <= tp_d;
    end
  end

  // Timing sequencer: each F10A rising edge emits the current slot and advances
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) tstate_q <= TS1;
    else     tstate_q <= tstate_d;
  end

  always_comb begin
    tstate_d = tstate_q;
    tp_d     = '0;
    if (f10a_rise) begin
      case (tstate_q)
        TS1:     begin tp_d = 6'b000001; tstate_d = TS2; end
        TS2:     begin tp_d = 6'b000010; tstate_d = TS3; end
        TS3:     begin tp_d = 6'b000100; tstate_d = TS4; end
        TS4:     begin tp_d = 6'b001000; tstate_d = TS5; end
        TS5:     begin tp_d = 6'b010000; tstate_d = TS6; end
        TS6:     begin tp_d = 6'b100000; tstate_d = TS1; end
        default: begin tp_d = '0;        tstate_d = TS1; end
      endcase
    end
  end

  assign T1P = tp_q[1];
  assign T2P = tp_q[2];
  assign T3P = tp_q[3];
  assign T4P = tp_q[4];
  assign T5P = tp_q[5];
  assign T6P = tp_q[6] & ~T6ON_;

  assign unused_ok = ^{XB6_, XB7_, CXB0_, WOVR_, FS10, F07C_, F07D_, F7CSB1_, SB1_,
                       GTSET_, CSG, CGA19, BR1, BR1_, SIGNX, SIGNY, SIGNZ,
                       GATEX_, GATEY_, GATEZ_};

endmodule

`default_nettype wire

// File: tb/tb_agc_a19_io.sv
// tb_agc_a19_io: directed scoreboard bench for agc_a19_io.
`default_nettype none

module tb_agc_a19_io;

  logic CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  logic rst = 1'b1;
  logic CHWL01_ = 0, CHWL02_ = 0, CHWL03_ = 0, CHWL04_ = 0, CHWL05_ = 0, CHWL06_ = 0;
  logic CHWL07_ = 0, CHWL08_ = 0, CHWL09_ = 0, CHWL10_ = 0, CHWL11_ = 0, CHWL12_ = 0;
  logic WCH11_ = 0, WCH13_ = 0, WCH14_ = 0, RCH11_ = 0, RCH13_ = 0, RCH14_ = 0, RCH33_ = 0;
  logic CCH11 = 0, CCH13 = 0, CCH14 = 0;
  logic CCHG_ = 0, XT3_ = 0, XB3_ = 0, XB5_ = 0, XB6_ = 0, XB7_ = 0, CXB0_ = 0, CXB7_ = 0;
  logic CA2_ = 0, CA4_ = 0, CA5_ = 0, CA6_ = 0, CNTRSB_ = 0;
  logic POUT_ = 0, MOUT_ = 0, ZOUT_ = 0, OVF_ = 0, WOVR_ = 0, SHINC_ = 0;
  logic F04A = 0, F06B = 0, F07B = 0, F09B = 0, F10A = 0, F10B = 0, FS10 = 0;
  logic F05A_ = 0, F05B_ = 0, F07C_ = 0, F07D_ = 0, F7CSB1_ = 0, SB0_ = 0, SB1_ = 0, SB2_ = 0;
  logic GTSET = 0, GTSET_ = 0, GTONE = 0, GOJAM = 0, CSG = 0, CGA19 = 0, C45R = 0;
  logic T06_ = 0, T6ON_ = 0, BR1 = 0, BR1_ = 0;
  logic UPL0 = 0, UPL1 = 0, XLNK0 = 0, XLNK1 = 0, BLKUPL_ = 0;
  logic BMGXP = 0, BMGXM = 0, BMGYP = 0, BMGYM = 0, BMGZP = 0, BMGZM = 0;
  logic SIGNX = 0, SIGNY = 0, SIGNZ = 0, GATEX_ = 0, GATEY_ = 0, GATEZ_ = 0;

  logic BLKUPL, C45R_, F06B_, F09B_, F10A_, F10B_, UPL0_, UPL1_, XLNK0_, XLNK1_;
  logic F5ASB0, F5ASB0_, F5ASB2, F5ASB2_, F5BSB2, F5BSB2_, CCH33, W1110;
  logic BMAGXP, BMAGXM, BMAGYP, BMAGYM, BMAGZP, BMAGZM;
  logic FF1109, FF1110, FF1111, FF1112, FF1109_, FF1110_, FF1111_, FF1112_;
  logic CH1109, CH1110, CH1111, CH1112, CH1305, CH1306, CH1308, CH1309;
  logic CH1401, CH1402, CH1403, CH1404, CH1405, CH1406, CH1407, CH1408, CH1409, CH1410;
  logic CH3310, CH3311;
  logic GYENAB, GYROD, GYRSET, GYRRST, GYXP, GYXM, GYYP, GYYM, GYZP, GYZM;
  logic THRSTD, THRSTp, THRSTm, EMSD, EMSp, EMSm;
  logic ALTM, ALT0, ALT1, ALRT0, ALRT1, ALTSNC, OTLNK0, OTLNK1, OTLNKM;
  logic INLNKP, INLNKM, UPRUPT, RHCGO, SH3MS_, T1P, T2P, T3P, T4P, T5P, T6P;

  agc_a19_io dut (
    .CLOCK(CLOCK), .rst(rst),
    .CHWL01_(CHWL01_), .CHWL02_(CHWL02_), .CHWL03_(CHWL03_), .CHWL04_(CHWL04_),
    .CHWL05_(CHWL05_), .CHWL06_(CHWL06_), .CHWL07_(CHWL07_), .CHWL08_(CHWL08_),
    .CHWL09_(CHWL09_), .CHWL10_(CHWL10_), .CHWL11_(CHWL11_), .CHWL12_(CHWL12_),
    .WCH11_(WCH11_), .WCH13_(WCH13_), .WCH14_(WCH14_),
    .RCH11_(RCH11_), .RCH13_(RCH13_), .RCH14_(RCH14_), .RCH33_(RCH33_),
    .CCH11(CCH11), .CCH13(CCH13), .CCH14(CCH14),
    .CCHG_(CCHG_), .XT3_(XT3_), .XB3_(XB3_), .XB5_(XB5_), .XB6_(XB6_), .XB7_(XB7_),
    .CXB0_(CXB0_), .CXB7_(CXB7_), .CA2_(CA2_), .CA4_(CA4_), .CA5_(CA5_), .CA6_(CA6_),
    .CNTRSB_(CNTRSB_),
    .POUT_(POUT_), .MOUT_(MOUT_), .ZOUT_(ZOUT_), .OVF_(OVF_), .WOVR_(WOVR_), .SHINC_(SHINC_),
    .F04A(F04A), .F06B(F06B), .F07B(F07B), .F09B(F09B), .F10A(F10A), .F10B(F10B),
    .FS10(FS10), .F05A_(F05A_), .F05B_(F05B_), .F07C_(F07C_), .F07D_(F07D_),
    .F7CSB1_(F7CSB1_), .SB0_(SB0_), .SB1_(SB1_), .SB2_(SB2_),
    .GTSET(GTSET), .GTSET_(GTSET_), .GTONE(GTONE), .GOJAM(GOJAM), .CSG(CSG),
    .CGA19(CGA19), .C45R(C45R), .T06_(T06_), .T6ON_(T6ON_), .BR1(BR1), .BR1_(BR1_),
    .UPL0(UPL0), .UPL1(UPL1), .XLNK0(XLNK0), .XLNK1(XLNK1), .BLKUPL_(BLKUPL_),
    .BMGXP(BMGXP), .BMGXM(BMGXM), .BMGYP(BMGYP), .BMGYM(BMGYM), .BMGZP(BMGZP),
    .BMGZM(BMGZM), .SIGNX(SIGNX), .SIGNY(SIGNY), .SIGNZ(SIGNZ),
    .GATEX_(GATEX_), .GATEY_(GATEY_), .GATEZ_(GATEZ_),
    .BLKUPL(BLKUPL), .C45R_(C45R_), .F06B_(F06B_), .F09B_(F09B_), .F10A_(F10A_),
    .F10B_(F10B_), .UPL0_(UPL0_), .UPL1_(UPL1_), .XLNK0_(XLNK0_), .XLNK1_(XLNK1_),
    .F5ASB0(F5ASB0), .F5ASB0_(F5ASB0_), .F5ASB2(F5ASB2), .F5ASB2_(F5ASB2_),
    .F5BSB2(F5BSB2), .F5BSB2_(F5BSB2_), .CCH33(CCH33), .W1110(W1110),
    .BMAGXP(BMAGXP), .BMAGXM(BMAGXM), .BMAGYP(BMAGYP), .BMAGYM(BMAGYM),
    .BMAGZP(BMAGZP), .BMAGZM(BMAGZM),
    .FF1109(FF1109), .FF1110(FF1110), .FF1111(FF1111), .FF1112(FF1112),
    .FF1109_(FF1109_), .FF1110_(FF1110_), .FF1111_(FF1111_), .FF1112_(FF1112_),
    .CH1109(CH1109), .CH1110(CH1110), .CH1111(CH1111), .CH1112(CH1112),
    .CH1305(CH1305), .CH1306(CH1306), .CH1308(CH1308), .CH1309(CH1309),
    .CH1401(CH1401), .CH1402(CH1402), .CH1403(CH1403), .CH1404(CH1404),
    .CH1405(CH1405), .CH1406(CH1406), .CH1407(CH1407), .CH1408(CH1408),
    .CH1409(CH1409), .CH1410(CH1410), .CH3310(CH3310), .CH3311(CH3311),
    .GYENAB(GYENAB), .GYROD(GYROD), .GYRSET(GYRSET), .GYRRST(GYRRST),
    .GYXP(GYXP), .GYXM(GYXM), .GYYP(GYYP), .GYYM(GYYM), .GYZP(GYZP), .GYZM(GYZM),
    .THRSTD(THRSTD), .THRSTp(THRSTp), .THRSTm(THRSTm),
    .EMSD(EMSD), .EMSp(EMSp), .EMSm(EMSm),
    .ALTM(ALTM), .ALT0(ALT0), .ALT1(ALT1), .ALRT0(ALRT0), .ALRT1(ALRT1), .ALTSNC(ALTSNC),
    .OTLNK0(OTLNK0), .OTLNK1(OTLNK1), .OTLNKM(OTLNKM),
    .INLNKP(INLNKP), .INLNKM(INLNKM), .UPRUPT(UPRUPT), .RHCGO(RHCGO), .SH3MS_(SH3MS_),
    .T1P(T1P), .T2P(T2P), .T3P(T3P), .T4P(T4P), .T5P(T5P), .T6P(T6P)
  );

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   passes = 0;
  int   fails  = 0;
  int   total  = 0;

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) passes++;
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  function automatic logic [7:0] tvec();
    return {2'b00, T6P, T5P, T4P, T3P, T2P, T1P};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every input low
    cyc(2);
    push("rst_FF1109", 0);   push("rst_FF1109_", 1); push("rst_CH1401", 0);
    push("rst_UPRUPT", 0);   push("rst_T1P", 0);     push("idle_BLKUPL", 1);
    push("idle_C45R_", 1);   push("idle_F5ASB0", 1); push("idle_CCH33", 1);
    push("idle_RHCGO", 1);
    chk(FF1109); chk(FF1109_); chk(CH1401); chk(UPRUPT); chk(T1P);
    chk(BLKUPL); chk(C45R_); chk(F5ASB0); chk(CCH33); chk(RHCGO);

    WCH11_ = 1; WCH13_ = 1; WCH14_ = 1; RCH11_ = 1; RCH13_ = 1; RCH14_ = 1; RCH33_ = 1;
    OVF_ = 1; MOUT_ = 1; ZOUT_ = 1; BLKUPL_ = 1;
    {CHWL12_, CHWL11_, CHWL10_, CHWL09_, CHWL08_, CHWL07_} = '1;
    {CHWL06_, CHWL05_, CHWL04_, CHWL03_, CHWL02_, CHWL01_} = '1;
    rst = 0;
    cyc(1);
    push("post_rst_FF1110_", 1); push("post_rst_UPRUPT", 0);
    chk(FF1110_); chk(UPRUPT);

    // Channel 11 write / read / clear
    CHWL09_ = 0; WCH11_ = 0;
    #1 push("W1110_data0", 0); chk(W1110);
    cyc(1);
    WCH11_ = 1; CHWL09_ = 1; RCH11_ = 0;
    #1 push("ch11_FF1109", 1); push("ch11_FF1110", 0); push("ch11_CH1109", 1);
    push("ch11_FF1110_", 1);
    chk(FF1109); chk(FF1110); chk(CH1109); chk(FF1110_);
    CCH11 = 1;
    cyc(1);
    CCH11 = 0;
    #1 push("clr_FF1109", 0); push("clr_FF1109_", 1); push("clr_CH1109", 0);
    chk(FF1109); chk(FF1109_); chk(CH1109);

    // Write wins over a simultaneous clear
    WCH11_ = 0; CCH11 = 1; CHWL12_ = 0; CHWL10_ = 0;
    #1 push("W1110_data1", 1); chk(W1110);
    cyc(1);
    WCH11_ = 1; CCH11 = 0; CHWL12_ = 1; CHWL10_ = 1;
    #1 push("prio_FF1112", 1); push("prio_FF1110", 1); push("prio_FF1109", 0);
    push("prio_CH1112", 1);
    chk(FF1112); chk(FF1110); chk(FF1109); chk(CH1112);
    RCH11_ = 1;
    #1 push("noread_CH1112", 0); chk(CH1112);

    // Gyro X plus, strobe gating, X minus, Z plus
    CHWL06_ = 0; CHWL07_ = 0; CHWL10_ = 0; WCH14_ = 0;
    cyc(1);
    WCH14_ = 1; CHWL06_ = 1; CHWL07_ = 1; CHWL10_ = 1;
    #1 push("gy_GYENAB", 1); push("gy_GYROD", 1); push("gy_GYXP", 1); push("gy_GYXM", 0);
    push("gy_GYYP", 0); push("gy_GYZP", 0); push("gy_GYRRST", 0);
    chk(GYENAB); chk(GYROD); chk(GYXP); chk(GYXM); chk(GYYP); chk(GYZP); chk(GYRRST);
    SB2_ = 1;
    #1 push("gy_nostrobe_GYXP", 0); chk(GYXP);
    SB2_ = 0;
    CHWL06_ = 0; CHWL07_ = 0; CHWL09_ = 0; CHWL10_ = 0; WCH14_ = 0;
    cyc(1);
    WCH14_ = 1; CHWL06_ = 1; CHWL07_ = 1; CHWL09_ = 1; CHWL10_ = 1;
    #1 push("gyneg_GYXM", 1); push("gyneg_GYXP", 0); chk(GYXM); chk(GYXP);
    CHWL06_ = 0; CHWL07_ = 0; CHWL08_ = 0; CHWL10_ = 0; WCH14_ = 0;
    cyc(1);
    WCH14_ = 1; CHWL06_ = 1; CHWL07_ = 1; CHWL08_ = 1; CHWL10_ = 1; GTSET = 1;
    #1 push("gyz_GYZP", 1); push("gyz_GYXP", 0); push("gyz_GYRSET", 1);
    chk(GYZP); chk(GYXP); chk(GYRSET);
    GTSET = 0;

    // Thrust pulse registered one clock after the enable latch
    CHWL04_ = 0; WCH14_ = 0;
    cyc(1);
    WCH14_ = 1; CHWL04_ = 1;
    #1 push("thr_THRSTD", 1); push("thr_THRSTp_early", 0);
    chk(THRSTD); chk(THRSTp);
    cyc(1);
    push("thr_THRSTp", 1); push("thr_THRSTm", 0); push("thr_EMSp", 0);
    chk(THRSTp); chk(THRSTm); chk(EMSp);
    POUT_ = 1;
    cyc(1);
    push("thr_THRSTp_off", 0); chk(THRSTp);

    // UPRUPT set by overflow, cleared by C45R
    OVF_ = 0;
    cyc(1);
    push("uprupt_set", 1); chk(UPRUPT);
    C45R = 1;
    cyc(1);
    push("uprupt_clr", 0); push("C45R_low", 0); chk(UPRUPT); chk(C45R_);
    C45R = 0; OVF_ = 1;

    // Uplink pulses, blocking, too-fast latch
    UPL1 = 1;
    cyc(1);
    push("upl_INLNKP", 1); push("upl_INLNKM", 0); push("upl_BLKUPL", 0);
    chk(INLNKP); chk(INLNKM); chk(BLKUPL);
    cyc(1);
    push("upl_INLNKP_end", 0); chk(INLNKP);
    UPL1 = 0; RCH33_ = 0;
    cyc(1);
    push("upl_CH3311_clear", 0); push("upl_CH3310_unblk", 0); chk(CH3311); chk(CH3310);
    BLKUPL_ = 0; UPL1 = 1;
    cyc(1);
    push("blk_INLNKP", 0); push("blk_CH3310", 1); chk(INLNKP); chk(CH3310);
    cyc(1);
    push("blk_INLNKP_2", 0); chk(INLNKP);
    UPL1 = 0; XLNK0 = 1;
    cyc(1);
    push("xl_INLNKM", 1); push("xl_CH3311_pre", 0); chk(INLNKM); chk(CH3311);
    cyc(1);
    push("xl_CH3311", 1); chk(CH3311);
    XLNK0 = 0; RCH33_ = 1;

    // Timing pulses over seven F10A rising edges
    for (int k = 0; k < 7; k++) begin
      F10A = 1;
      cyc(1);
      push($sformatf("tp_edge%0d", k), 8'(1 << (k % 6)));
      chk(tvec());
      F10A = 0;
      cyc(1);
      if (k == 0) begin
        push("tp_oneclk", 0);
        chk(tvec());
      end
    end
    F10A = 1;
    cyc(1);
    push("tp_edge7", 8'h02); chk(tvec());
    F10A = 0;
    #2 rst = 1;
    cyc(1);
    rst = 0;
    cyc(1);
    F10A = 1;
    cyc(1);
    push("tp_after_rst", 8'h01); chk(tvec());
    F10A = 0;
    cyc(1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
